// File: rtl/noc_defs.sv
// Shared NoC definitions: default router port geometry and width helpers.
package noc_defs;

  // Default number of virtual channels sharing one output link.
  localparam int NOC_NUM_VC    = 4;
  // Default downstream per-VC buffer depth in flits (also the initial credit count).
  localparam int NOC_BUF_DEPTH = 4;

  // Width of a VC id; a single-VC link still needs one bit.
  function automatic int vc_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/output_vc_flow_control_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after last_grant.
module rr_arbiter
  import noc_defs::*;
#(
  parameter int N = NOC_NUM_VC
) (
  input  logic [N-1:0]              req,
  input  logic [vc_width(N)-1:0]    last_grant,
  output logic [N-1:0]              grant,
  output logic                      grant_valid
);

  logic [N-1:0] w_upper_req;

  // Requests with an index above last_grant are searched first.
  always_comb begin
    w_upper_req = '0;
    for (int i = 0; i < N; i++) begin
      w_upper_req[i] = req[i] & (i > int'(last_grant));
    end
  end

  // Lowest upper request wins; otherwise wrap around to the lowest request overall.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && w_upper_req[i]) begin
        grant[i]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!grant_valid && req[i]) begin
        grant[i]    = 1'b1;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_vc_flow_control.sv
// Output-port VC flow control: credit tracking per VC and round-robin link scheduling.
module output_vc_flow_control
  import noc_defs::*;
#(
  parameter int NUM_VC    = NOC_NUM_VC,
  parameter int BUF_DEPTH = NOC_BUF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_VC-1:0]           empty,
  input  logic [NUM_VC-1:0]           ret,
  output logic [NUM_VC-1:0]           read,
  output logic                        val,
  output logic [vc_width(NUM_VC)-1:0] out_vc,
  output logic [NUM_VC-1:0]           credit_avail,
  output logic                        credit_err
);

  localparam int VCW = vc_width(NUM_VC);
  localparam int CW  = cnt_width(BUF_DEPTH);

  logic [NUM_VC-1:0] w_req;
  logic [NUM_VC-1:0] w_grant;
  logic [NUM_VC-1:0] w_ovf;
  logic              w_grant_valid;
  logic [VCW-1:0]    w_grant_idx;
  logic [VCW-1:0]    r_last_grant;

  rr_arbiter #(.N(NUM_VC)) u_arb (
    .req         (w_req),
    .last_grant  (r_last_grant),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  // The pop strobe must fall the moment reset asserts, not at the next edge.
  assign read = w_grant & {NUM_VC{rst_n}};

  // Per-VC credit counter: grant consumes, return restores, both together cancel.
  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_credit
    logic [CW-1:0] r_credit;

    assign credit_avail[gi] = (r_credit != '0);
    assign w_req[gi]        = ~empty[gi] & credit_avail[gi];
    assign w_ovf[gi]        = ret[gi] & ~w_grant[gi] & (r_credit == CW'(BUF_DEPTH));

    // Count update; a return into a full counter saturates and is flagged separately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_credit <= CW'(BUF_DEPTH);
      end else if (w_grant[gi] && !ret[gi]) begin
        r_credit <= r_credit - CW'(1);
      end else if (ret[gi] && !w_grant[gi] && !w_ovf[gi]) begin
        r_credit <= r_credit + CW'(1);
      end
    end
  end

  // Encode the one-hot grant into a VC id.
  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (w_grant[i]) begin
        w_grant_idx = VCW'(i);
      end
    end
  end

  // Link outputs trail the grant by one cycle to line up with registered FIFO data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val    <= 1'b0;
      out_vc <= '0;
    end else begin
      val    <= w_grant_valid;
      out_vc <= w_grant_valid ? w_grant_idx : '0;
    end
  end

  // Round-robin pointer moves only on a grant; reset leaves VC0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= VCW'(NUM_VC - 1);
    end else if (w_grant_valid) begin
      r_last_grant <= w_grant_idx;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_err <= 1'b0;
    end else if (|w_ovf) begin
      credit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_vc_flow_control.sv
// Scoreboard bench for output_vc_flow_control with a behavioural credit/round-robin model.
module tb_output_vc_flow_control;

  localparam int NV = 4;
  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] empty = 4'h0;
  logic [3:0] ret = 4'h0;
  logic [3:0] read;
  logic       val;
  logic [1:0] out_vc;
  logic [3:0] credit_avail;
  logic       credit_err;

  always #5 clk = ~clk;

  output_vc_flow_control #(.NUM_VC(NV), .BUF_DEPTH(BD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .empty        (empty),
    .ret          (ret),
    .read         (read),
    .val          (val),
    .out_vc       (out_vc),
    .credit_avail (credit_avail),
    .credit_err   (credit_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int m_credit[NV];
  int m_last;
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_credit[v] = BD;
    m_last = NV - 1;
    m_err  = 1'b0;
    exp_q.delete();
    exp_q.push_back(-1);
  endtask

  // One cycle: drive, check at negedge, advance model, push expected link output.
  task automatic step(input logic [3:0] e, input logic [3:0] r, output int g);
    int ev;
    int idx;
    logic [3:0] exp_read;
    logic [3:0] exp_avail;
    empty = e;
    ret   = r;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("queue_underflow", 32'(1), 32'(0));
    end else begin
      ev = exp_q.pop_front();
      check_eq("val", 32'(val), 32'(ev >= 0));
      if (ev >= 0) check_eq("out_vc", 32'(out_vc), 32'(ev));
    end
    g = -1;
    for (int k = 1; k <= NV; k++) begin
      idx = (m_last + k) % NV;
      if (g < 0 && !e[idx[1:0]] && m_credit[idx] > 0) g = idx;
    end
    exp_read = 4'h0;
    if (g >= 0) exp_read[g[1:0]] = 1'b1;
    for (int v = 0; v < NV; v++) exp_avail[v] = (m_credit[v] > 0);
    check_eq("read", 32'(read), 32'(exp_read));
    check_eq("credit_avail", 32'(credit_avail), 32'(exp_avail));
    check_eq("credit_err", 32'(credit_err), 32'(m_err));
    for (int v = 0; v < NV; v++) begin
      if (g == v && !r[v]) m_credit[v]--;
      else if (r[v] && g != v) begin
        if (m_credit[v] == BD) m_err = 1'b1;
        else m_credit[v]++;
      end
    end
    if (g >= 0) m_last = g;
    exp_q.push_back(g);
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check outputs respond before any edge, release mid-cycle.
  task automatic do_reset();
    empty = 4'h0;
    ret   = 4'h0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_read", 32'(read), 32'(0));
    check_eq("rst_val", 32'(val), 32'(0));
    check_eq("rst_out_vc", 32'(out_vc), 32'(0));
    check_eq("rst_avail", 32'(credit_avail), 32'(4'hF));
    check_eq("rst_err", 32'(credit_err), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int g;
    int cnt;
    @(posedge clk);
    #1;
    do_reset();

    // All empty after reset: nothing moves.
    for (int i = 0; i < 3; i++) step(4'hF, 4'h0, g);

    // Round robin across all four VCs.
    for (int i = 0; i < 4; i++) begin
      step(4'h0, 4'h0, g);
      check_eq("rr_order", 32'(g), 32'(i));
    end
    step(4'hF, 4'h0, g);

    // Credit exhaustion on VC2, then one return buys exactly one more flit.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b1011, 4'h0, g);
      if (g == 2) cnt++;
    end
    check_eq("exhaust_cnt", 32'(cnt), 32'(4));
    step(4'b1011, 4'b0100, g);
    check_eq("ret_cycle_grant", 32'(g), 32'(-1));
    step(4'b1011, 4'h0, g);
    check_eq("after_ret_grant", 32'(g), 32'(2));
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      step(4'b1011, 4'h0, g);
      if (g >= 0) cnt++;
    end
    check_eq("after_ret_extra", 32'(cnt), 32'(0));

    // Grant and return on VC1 in the same cycle leave its credit at 2.
    do_reset();
    step(4'b1101, 4'h0, g);
    step(4'b1101, 4'h0, g);
    step(4'b1101, 4'b0010, g);
    check_eq("simul_grant", 32'(g), 32'(1));
    step(4'hF, 4'h0, g);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(4'b1101, 4'h0, g);
      if (g == 1) cnt++;
    end
    check_eq("simul_remaining", 32'(cnt), 32'(2));

    // Return into a full VC3: saturate and raise the sticky error.
    do_reset();
    step(4'hF, 4'b1000, g);
    for (int i = 0; i < 3; i++) step(4'hF, 4'h0, g);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0111, 4'h0, g);
      if (g == 3) cnt++;
    end
    check_eq("ovf_credit_kept", 32'(cnt), 32'(4));

    // Random traffic with sparse returns.
    for (int i = 0; i < 150; i++) begin
      step(4'($urandom), 4'($urandom & $urandom & $urandom), g);
    end

    // Reset mid-stream, then lowest non-empty VC gets the first grant.
    for (int i = 0; i < 2; i++) step(4'h0, 4'h0, g);
    do_reset();
    step(4'b1001, 4'h0, g);
    check_eq("post_rst_first", 32'(g), 32'(1));
    for (int i = 0; i < 3; i++) step(4'hF, 4'h0, g);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
